bf16_add_sched: RTL and testbench

//  Shares one bfloat16 adder (CW_fp_add, sig_width=7, exp_width=8) between NUM_REQ requesters.

---
 rtl/bf16_pkg.sv | 26 ++
 rtl/CW_fp_add.sv | 107 ++++++++++
 rtl/bf16_rr_arb.sv | 29 ++
 rtl/bf16_add_sched.sv | 150 +++++++++++++++
 tb/tb_bf16_add_sched.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared types for the bf16 adder scheduler.
// Operand/result bundles that travel through the shared-adder pipe.
package bf16_pkg;
  localparam int BF16_W = 16;
  localparam int EXP_W = 8;
  localparam int SIG_W = 7;
  localparam int TXN_ID_W = 2;
  localparam int TXN_TAG_W = 4;

  typedef logic [BF16_W-1:0] bf16_t;

  typedef struct packed {
    bf16_t a;
    bf16_t b;
    logic [2:0] rnd;
    logic [TXN_ID_W-1:0] id;
    logic [TXN_TAG_W-1:0] tag;
  } add_txn_t;

  typedef struct packed {
    bf16_t z;
    logic [7:0] status;
    logic [TXN_ID_W-1:0] id;
    logic [TXN_TAG_W-1:0] tag;
  } add_rsp_t;
endpackage

// File: rtl/CW_fp_add.sv
// Combinational floating-point adder, denormals flushed to zero.
// status: 0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact.
module CW_fp_add #(
  parameter int sig_width = 7,
  parameter int exp_width = 8
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);
  localparam int S = sig_width;
  localparam int E = exp_width;
  localparam int W = S + 4;
  localparam int XW = E + 2;
  localparam logic [E-1:0] EMAX = '1;

  logic sa, sb, sx, sy, swap;
  logic [E-1:0] ea, eb, ex, ey, d;
  logic [S-1:0] fa, fb, fx, fy, fz;
  logic [W-1:0] mx, my, mys;
  logic [W:0] sum;
  logic [XW-1:0] e;
  logic [S+1:0] rsum;
  logic g, st, inc, found;
  int lz;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    z = '0;
    status = '0;
    lz = 0;
    found = 1'b0;
    inc = 1'b0;
    fz = '0;
    swap = {eb, fb} > {ea, fa};
    {sx, ex, fx} = swap ? b : a;
    {sy, ey, fy} = swap ? a : b;
    mx = {1'b1, fx, 3'b000};
    my = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
    d = ex - ey;
    // aligned operand keeps a sticky bit for everything shifted out
    if (int'(d) >= W)
      mys = {{(W-1){1'b0}}, |my};
    else
      mys = (my >> d) |
            {{(W-1){1'b0}}, |(my & ~({W{1'b1}} << d))};
    e = {2'b00, ex};
    if (sx == sy) sum = {1'b0, mx} + {1'b0, mys};
    else sum = {1'b0, mx} - {1'b0, mys};
    if (sum[W]) begin
      sum = {1'b0, sum[W:2], sum[1] | sum[0]};
      e = e + XW'(1);
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz = W - 1 - i;
        found = 1'b1;
      end
    end
    sum = sum << lz;
    e = e - XW'(lz);
    g = sum[2];
    st = sum[1] | sum[0];
    case (rnd)
      3'd1: inc = 1'b0;
      3'd2: inc = ~sx & (g | st);
      3'd3: inc = sx & (g | st);
      3'd4: inc = g;
      3'd5: inc = g | st;
      default: inc = g & (st | sum[3]);
    endcase
    rsum = {1'b0, sum[W-1:3]} + {{(S+1){1'b0}}, inc};
    if (rsum[S+1]) begin
      e = e + XW'(1);
      fz = '0;
    end else begin
      fz = rsum[S-1:0];
    end
    if ((ea == EMAX && fa != '0) || (eb == EMAX && fb != '0) ||
        (ea == EMAX && eb == EMAX && sa != sb)) begin
      z = {1'b0, EMAX, 1'b1, {(S-1){1'b0}}};
      status[2] = 1'b1;
    end else if (ea == EMAX || eb == EMAX) begin
      z = {sx, EMAX, {S{1'b0}}};
      status[1] = 1'b1;
    end else if (ex == '0 || !found) begin
      z = {(ex == '0) ? (sa & sb) : (rnd == 3'd3), {(E+S){1'b0}}};
      status[0] = 1'b1;
    end else if (e[XW-1] || e == '0) begin
      z = {sx, {(E+S){1'b0}}};
      status[0] = 1'b1;
      status[3] = 1'b1;
      status[5] = 1'b1;
    end else if (e >= {2'b00, EMAX}) begin
      z = {sx, EMAX, {S{1'b0}}};
      status[1] = 1'b1;
      status[4] = 1'b1;
      status[5] = 1'b1;
    end else begin
      z = {sx, e[E-1:0], fz};
      status[5] = g | st;
    end
  end
endmodule

// File: rtl/bf16_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr, cyclic.
module bf16_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        idx = ID_W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bf16_add_sched.sv
// Shares one bf16 adder among NUM_REQ requesters; in-order
// results through a credit-guarded output FIFO.
module bf16_add_sched
  import bf16_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PIPE_STAGES = 2,
  parameter int OUT_DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*16-1:0]    req_a,
  input  logic [NUM_REQ*16-1:0]    req_b,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic [2:0]               rnd_mode,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_z,
  output logic [7:0]               rsp_status,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy
);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);

  logic run, gany, issue_ok, accept, pop, s0_v, wr_v;
  logic [ID_W-1:0] rr_ptr, gidx;
  logic [OCC_W-1:0] occ, cnt;
  logic [PTR_W-1:0] wp, rp;
  add_txn_t txn, s0;
  add_rsp_t r0, wr_d, head;
  add_rsp_t mem [OUT_DEPTH];
  bf16_t add_z;
  logic [7:0] add_st;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // run keeps grants off while reset is asserted
  assign issue_ok = run && (occ < OCC_W'(OUT_DEPTH));
  assign accept = gany;

  bf16_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .en  (issue_ok),
    .ptr (rr_ptr),
    .gnt (req_ready),
    .idx (gidx),
    .any (gany)
  );

  assign txn = {req_a[BF16_W*int'(gidx) +: BF16_W],
                req_b[BF16_W*int'(gidx) +: BF16_W],
                rnd_mode,
                TXN_ID_W'(gidx),
                TXN_TAG_W'(req_tag[TAG_W*int'(gidx) +: TAG_W])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      rr_ptr <= '0;
      occ <= '0;
      s0_v <= 1'b0;
      s0 <= '0;
    end else begin
      run <= 1'b1;
      s0_v <= accept;
      if (accept) begin
        s0 <= txn;
        rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
      end
      case ({accept, pop})
        2'b10: occ <= occ + OCC_W'(1);
        2'b01: occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  CW_fp_add #(.sig_width(SIG_W), .exp_width(EXP_W)) u_add (
    .a      (s0.a),
    .b      (s0.b),
    .rnd    (s0.rnd),
    .z      (add_z),
    .status (add_st)
  );

  assign r0 = {add_z, add_st, s0.id, s0.tag};

  if (PIPE_STAGES == 1) begin : g_direct
    assign wr_v = s0_v;
    assign wr_d = r0;
  end else begin : g_pipe
    logic [PIPE_STAGES-2:0] pv;
    add_rsp_t pd [PIPE_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int k = 0; k < PIPE_STAGES - 1; k++) pd[k] <= '0;
      end else begin
        pv[0] <= s0_v;
        pd[0] <= r0;
        for (int k = 1; k < PIPE_STAGES - 1; k++) begin
          pv[k] <= pv[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end

    assign wr_v = pv[PIPE_STAGES-2];
    assign wr_d = pd[PIPE_STAGES-2];
  end

  // credit guarantees a free slot for every write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_v) begin
        mem[wp] <= wr_d;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      case ({wr_v, pop})
        2'b10: cnt <= cnt + OCC_W'(1);
        2'b01: cnt <= cnt - OCC_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = mem[rp];
  assign rsp_valid = (cnt != '0);
  assign pop = rsp_valid & rsp_ready;
  assign rsp_z = rsp_valid ? head.z : '0;
  assign rsp_status = rsp_valid ? head.status : '0;
  assign rsp_id = rsp_valid ? ID_W'(head.id) : '0;
  assign rsp_tag = rsp_valid ? TAG_W'(head.tag) : '0;
  assign busy = (occ != '0);
endmodule

// File: tb/tb_bf16_add_sched.sv
// Bench for bf16_add_sched: directed scenarios plus random traffic
// against a cycle-level reference of arbitration, credit and ordering.
module tb_bf16_add_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready;
  logic [63:0] req_a, req_b;
  logic [15:0] req_tag;
  logic [2:0] rnd_mode;
  logic rsp_valid, rsp_ready, busy;
  logic [15:0] rsp_z;
  logic [7:0] rsp_status;
  logic [1:0] rsp_id;
  logic [3:0] rsp_tag;

  typedef struct {
    logic [15:0] z;
    int id;
    logic [3:0] tag;
    int due;
  } exp_t;

  exp_t q[$];
  int m_rr, m_occ, cyc;
  int n_err, n_chk;

  bf16_add_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .rnd_mode   (rnd_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_status (rsp_status),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // integer value to bf16, round to nearest even
  function automatic logic [15:0] int2bf(input int v);
    int m, p, q2, r, half;
    logic s;
    if (v == 0) return 16'h0000;
    s = (v < 0);
    m = s ? -v : v;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 7) begin
      q2 = m << (7 - p);
    end else begin
      r = m & ((1 << (p - 7)) - 1);
      q2 = m >> (p - 7);
      half = 1 << (p - 8);
      if (r > half || (r == half && (q2 & 1) == 1)) q2++;
      if (q2 == 256) begin
        q2 = 128;
        p++;
      end
    end
    return {s, 8'(127 + p), 7'(q2 & 127)};
  endfunction

  function automatic int bf2int(input logic [15:0] x);
    int e, m, p, v;
    e = int'(x[14:7]);
    if (e == 0) return 0;
    m = 128 | int'(x[6:0]);
    p = e - 127;
    v = (p >= 7) ? (m << (p - 7)) : (m >> (7 - p));
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a,
                                          input logic [15:0] b);
    if (a[14:7] == 8'hFF) return a;
    if (b[14:7] == 8'hFF) return b;
    return int2bf(bf2int(a) + bf2int(b));
  endfunction

  function automatic logic [15:0] rand_bf();
    return int2bf(int'($urandom_range(0, 510)) - 255);
  endfunction

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] t);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_tag[4*i +: 4] = t;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) set_op(i, rand_bf(), rand_bf(), 4'($urandom));
  endtask

  // one clock: check outputs mid-cycle, advance model, move past edge
  task automatic step();
    int g;
    logic [3:0] eg;
    logic ev, pop;
    exp_t e;
    @(negedge clk);
    g = -1;
    eg = '0;
    if (m_occ < 4) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(eg));
    ev = (q.size() > 0) && (q[0].due <= cyc);
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      check("rsp_z", 32'(rsp_z), 32'(q[0].z));
      check("rsp_id", 32'(rsp_id), q[0].id);
      check("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
    end
    check("busy", 32'(busy), 32'(m_occ != 0));
    pop = ev && rsp_ready;
    if (pop) void'(q.pop_front());
    if (g >= 0) begin
      e.z = ref_add(req_a[16*g +: 16], req_b[16*g +: 16]);
      e.id = g;
      e.tag = req_tag[4*g +: 4];
      e.due = cyc + 3;
      q.push_back(e);
      m_rr = (g + 1) % 4;
    end
    m_occ = m_occ + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_z", 32'(rsp_z), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    check("rst_rsp_status", 32'(rsp_status), 0);
    q.delete();
    m_rr = 0;
    m_occ = 0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    cyc = 0;
    m_rr = 0;
    m_occ = 0;
    rst_n = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    rnd_mode = 3'd0;
    rsp_ready = 1'b0;
    #2;
    do_reset();

    // single transaction, 1 + 2
    rsp_ready = 1'b1;
    set_op(0, 16'h3F80, 16'h4000, 4'd5);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    steps(2);
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_z", 32'(rsp_z), 32'h4040);
    steps(2);

    // full load, continuous round robin
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    steps(6);

    // backpressure: credit runs out at OUT_DEPTH
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    steps(8);
    check("bp_ready", 32'(req_ready), 0);
    check("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    steps(10);
    req_valid = '0;
    steps(6);

    // fairness after a grant to req2
    req_valid = 4'b0100;
    step();
    req_valid = 4'b1001;
    steps(2);
    req_valid = '0;
    steps(6);

    // reset with transactions in flight
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    steps(3);
    do_reset();
    steps(5);
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    step();
    req_valid = '0;
    steps(6);

    // arithmetic corners; rnd change after accept has no effect
    set_op(0, 16'h4000, 16'hC000, 4'd1);
    req_valid = 4'b0001;
    step();
    set_op(0, 16'h7F80, 16'h3F80, 4'd2);
    step();
    set_op(0, 16'h437F, 16'h4080, 4'd3);
    step();
    req_valid = '0;
    rnd_mode = 3'd1;
    steps(6);
    rnd_mode = 3'd0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    steps(10);
    check("end_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
